// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register: captures the decode control bundle, operands, immediate,
// destination and PC for the EX stage, with hold, flush, valid tag and a saturating bubble counter.
module id_ex_stage_reg #(
   parameter int DATA_W     = 8,
   parameter int REG_ADDR_W = 3,
   parameter int PC_W       = 10,
   parameter int CNT_W      = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  writeEnable_in,
   input  logic                  memRead_in,
   input  logic                  memWrite_in,
   input  logic                  branch_in,
   input  logic                  ALUSrc_in,
   input  logic                  MemToReg_in,
   input  logic [2:0]            OP_in,
   input  logic                  id_valid,
   input  logic [DATA_W-1:0]     rd1_in,
   input  logic [DATA_W-1:0]     rd2_in,
   input  logic [DATA_W-1:0]     imm_in,
   input  logic [REG_ADDR_W-1:0] dst_in,
   input  logic [PC_W-1:0]       pc_in,
   input  logic                  hold,
   input  logic                  flush,
   output logic                  writeEnable,
   output logic                  memRead,
   output logic                  memWrite,
   output logic                  branch,
   output logic                  ALUSrc,
   output logic                  MemToReg,
   output logic [2:0]            OP,
   output logic                  ex_valid,
   output logic [DATA_W-1:0]     rd1,
   output logic [DATA_W-1:0]     rd2,
   output logic [DATA_W-1:0]     imm,
   output logic [REG_ADDR_W-1:0] dst,
   output logic [PC_W-1:0]       pc,
   output logic [CNT_W-1:0]      bubble_count
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic             bubble;
   logic [CNT_W-1:0] count_next;

   // A bubble enters EX on any flush, or on a load edge carrying no real instruction.
   always_comb begin
      bubble     = 1'b0;
      count_next = bubble_count;
      if (flush) begin
         bubble = 1'b1;
      end else if (!hold && !id_valid) begin
         bubble = 1'b1;
      end else begin
         bubble = 1'b0;
      end
      if (bubble && (bubble_count != CNT_MAX)) begin
         count_next = bubble_count + CNT_ONE;
      end else begin
         count_next = bubble_count;
      end
   end

   // Pipeline register with priority flush > hold > load; control is not re-gated by id_valid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         writeEnable <= 1'b0;
         memRead     <= 1'b0;
         memWrite    <= 1'b0;
         branch      <= 1'b0;
         ALUSrc      <= 1'b0;
         MemToReg    <= 1'b0;
         OP          <= 3'b000;
         ex_valid    <= 1'b0;
         rd1         <= {DATA_W{1'b0}};
         rd2         <= {DATA_W{1'b0}};
         imm         <= {DATA_W{1'b0}};
         dst         <= {REG_ADDR_W{1'b0}};
         pc          <= {PC_W{1'b0}};
      end else if (flush) begin
         writeEnable <= 1'b0;
         memRead     <= 1'b0;
         memWrite    <= 1'b0;
         branch      <= 1'b0;
         ALUSrc      <= 1'b0;
         MemToReg    <= 1'b0;
         OP          <= 3'b000;
         ex_valid    <= 1'b0;
         rd1         <= {DATA_W{1'b0}};
         rd2         <= {DATA_W{1'b0}};
         imm         <= {DATA_W{1'b0}};
         dst         <= {REG_ADDR_W{1'b0}};
         pc          <= {PC_W{1'b0}};
      end else if (hold) begin
         writeEnable <= writeEnable;
         memRead     <= memRead;
         memWrite    <= memWrite;
         branch      <= branch;
         ALUSrc      <= ALUSrc;
         MemToReg    <= MemToReg;
         OP          <= OP;
         ex_valid    <= ex_valid;
         rd1         <= rd1;
         rd2         <= rd2;
         imm         <= imm;
         dst         <= dst;
         pc          <= pc;
      end else begin
         writeEnable <= writeEnable_in;
         memRead     <= memRead_in;
         memWrite    <= memWrite_in;
         branch      <= branch_in;
         ALUSrc      <= ALUSrc_in;
         MemToReg    <= MemToReg_in;
         OP          <= OP_in;
         ex_valid    <= id_valid;
         rd1         <= rd1_in;
         rd2         <= rd2_in;
         imm         <= imm_in;
         dst         <= dst_in;
         pc          <= pc_in;
      end
   end

   // Saturating bubble counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bubble_count <= {CNT_W{1'b0}};
      end else begin
         bubble_count <= count_next;
      end
   end

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Scoreboard bench for id_ex_stage_reg: stimulus pushes hand-computed expectations,
// a monitor pops and compares them after each clock edge or mid-cycle probe.
module tb_id_ex_stage_reg;

   typedef struct packed {
      logic [5:0] ctl;   // {writeEnable, memRead, memWrite, branch, ALUSrc, MemToReg}
      logic [2:0] op;
      logic       v;
      logic [7:0] rd1;
      logic [7:0] rd2;
      logic [7:0] imm;
      logic [2:0] dst;
      logic [9:0] pc;
      logic [3:0] bc;
   } out_t;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       we_i, mr_i, mw_i, br_i, as_i, m2r_i;
   logic [2:0] op_i;
   logic       id_valid;
   logic [7:0] rd1_i, rd2_i, imm_i;
   logic [2:0] dst_i;
   logic [9:0] pc_i;
   logic       hold, flush;
   logic       we, mr, mw, br, as, m2r;
   logic [2:0] op;
   logic       ex_valid;
   logic [7:0] rd1, rd2, imm;
   logic [2:0] dst;
   logic [9:0] pc;
   logic [3:0] bubble_count;

   int   errors = 0;
   int   checks = 0;
   logic probe  = 1'b0;
   out_t  exp_q[$];
   string name_q[$];

   always #5 clk = ~clk;

   id_ex_stage_reg #(.DATA_W(8), .REG_ADDR_W(3), .PC_W(10), .CNT_W(4)) dut (
      .clk(clk), .rst_n(rst_n),
      .writeEnable_in(we_i), .memRead_in(mr_i), .memWrite_in(mw_i),
      .branch_in(br_i), .ALUSrc_in(as_i), .MemToReg_in(m2r_i),
      .OP_in(op_i), .id_valid(id_valid),
      .rd1_in(rd1_i), .rd2_in(rd2_i), .imm_in(imm_i), .dst_in(dst_i), .pc_in(pc_i),
      .hold(hold), .flush(flush),
      .writeEnable(we), .memRead(mr), .memWrite(mw), .branch(br), .ALUSrc(as), .MemToReg(m2r),
      .OP(op), .ex_valid(ex_valid), .rd1(rd1), .rd2(rd2), .imm(imm), .dst(dst), .pc(pc),
      .bubble_count(bubble_count)
   );

   function automatic out_t mk(input logic [5:0] c, input logic [2:0] o, input logic v,
                               input logic [7:0] r1, input logic [7:0] r2, input logic [7:0] im,
                               input logic [2:0] d, input logic [9:0] p, input logic [3:0] bc);
      out_t t;
      t.ctl = c; t.op = o; t.v = v; t.rd1 = r1; t.rd2 = r2; t.imm = im;
      t.dst = d; t.pc = p; t.bc = bc;
      return t;
   endfunction

   task automatic drive(input logic [5:0] c, input logic [2:0] o, input logic v,
                        input logic [7:0] r1, input logic [7:0] r2, input logic [7:0] im,
                        input logic [2:0] d, input logic [9:0] p, input logic h, input logic f);
      {we_i, mr_i, mw_i, br_i, as_i, m2r_i} = c;
      op_i = o; id_valid = v; rd1_i = r1; rd2_i = r2; imm_i = im;
      dst_i = d; pc_i = p; hold = h; flush = f;
   endtask

   task automatic expect_out(input string name, input out_t e);
      exp_q.push_back(e);
      name_q.push_back(name);
   endtask

   task automatic pulse_probe();
      probe = 1'b1;
      #1;
      probe = 1'b0;
   endtask

   task automatic step(input string name, input logic [5:0] c, input logic [2:0] o, input logic v,
                       input logic [7:0] r1, input logic [7:0] r2, input logic [7:0] im,
                       input logic [2:0] d, input logic [9:0] p, input logic h, input logic f,
                       input out_t e);
      @(negedge clk);
      drive(c, o, v, r1, r2, im, d, p, h, f);
      expect_out(name, e);
   endtask

   // Monitor: compares the oldest expectation after every clock edge or probe.
   initial begin
      out_t  e;
      out_t  a;
      string n;
      forever begin
         @(posedge clk or posedge probe);
         #1;
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n = name_q.pop_front();
            a = mk({we, mr, mw, br, as, m2r}, op, ex_valid, rd1, rd2, imm, dst, pc, bubble_count);
            checks++;
            if (a !== e) begin
               errors++;
               $display("FAIL %s: got %h expected %h", n, a, e);
            end
         end
      end
   end

   initial begin
      out_t zero;
      out_t e_load;
      out_t e_stall;
      int   wait_cnt;
      zero = mk(6'b000000, 3'b000, 1'b0, 8'h00, 8'h00, 8'h00, 3'd0, 10'h000, 4'd0);

      rst_n = 1'b0;
      drive(6'b000000, 3'b000, 1'b0, 8'h00, 8'h00, 8'h00, 3'd0, 10'h000, 1'b1, 1'b0);
      #3;
      expect_out("reset_state", zero);
      pulse_probe();
      @(negedge clk);
      rst_n = 1'b1;

      e_load = mk(6'b100000, 3'b101, 1'b1, 8'h3C, 8'hA5, 8'hF0, 3'd4, 10'h012, 4'd0);
      step("load", 6'b100000, 3'b101, 1'b1, 8'h3C, 8'hA5, 8'hF0, 3'd4, 10'h012, 1'b0, 1'b0, e_load);
      for (int i = 0; i < 3; i++) begin
         step("hold", 6'b011111, 3'b010, 1'b0, 8'h11, 8'h22, 8'h33, 3'd1, 10'h3FF, 1'b1, 1'b0, e_load);
      end

      step("load_memwrite", 6'b001010, 3'b011, 1'b1, 8'h5A, 8'hC3, 8'h01, 3'd7, 10'h200, 1'b0, 1'b0,
           mk(6'b001010, 3'b011, 1'b1, 8'h5A, 8'hC3, 8'h01, 3'd7, 10'h200, 4'd0));
      step("flush_beats_hold", 6'b001000, 3'b110, 1'b1, 8'hFF, 8'hEE, 8'hDD, 3'd5, 10'h1FF, 1'b1, 1'b1,
           mk(6'b000000, 3'b000, 1'b0, 8'h00, 8'h00, 8'h00, 3'd0, 10'h000, 4'd1));

      step("stall_1", 6'b000000, 3'b000, 1'b0, 8'h77, 8'h66, 8'h55, 3'd2, 10'h0AB, 1'b0, 1'b0,
           mk(6'b000000, 3'b000, 1'b0, 8'h77, 8'h66, 8'h55, 3'd2, 10'h0AB, 4'd2));
      e_stall = mk(6'b000000, 3'b000, 1'b0, 8'h77, 8'h66, 8'h55, 3'd2, 10'h0AB, 4'd3);
      step("stall_2", 6'b000000, 3'b000, 1'b0, 8'h77, 8'h66, 8'h55, 3'd2, 10'h0AB, 1'b0, 1'b0, e_stall);

      // New inputs mid-cycle must not reach the outputs before the edge.
      @(negedge clk);
      drive(6'b110101, 3'b111, 1'b1, 8'h81, 8'h42, 8'h24, 3'd6, 10'h155, 1'b0, 1'b0);
      expect_out("no_comb_path", e_stall);
      expect_out("load_multi", mk(6'b110101, 3'b111, 1'b1, 8'h81, 8'h42, 8'h24, 3'd6, 10'h155, 4'd3));
      #2;
      pulse_probe();

      @(negedge clk);
      drive(6'b111111, 3'b111, 1'b1, 8'h99, 8'h88, 8'h77, 3'd3, 10'h321, 1'b1, 1'b1);
      #2;
      rst_n = 1'b0;
      expect_out("async_reset", zero);
      expect_out("reset_over_edge", zero);
      pulse_probe();
      @(negedge clk);
      rst_n = 1'b1;
      drive(6'b000000, 3'b000, 1'b0, 8'h00, 8'h00, 8'h00, 3'd0, 10'h000, 1'b1, 1'b0);

      for (int i = 1; i <= 18; i++) begin
         step("saturate", 6'b111111, 3'b111, 1'b1, 8'hAB, 8'hCD, 8'hEF, 3'd7, 10'h3AA,
              (i % 2) == 1, 1'b1,
              mk(6'b000000, 3'b000, 1'b0, 8'h00, 8'h00, 8'h00, 3'd0, 10'h000,
                 (i > 15) ? 4'd15 : 4'(i)));
      end
      step("sat_hold", 6'b101010, 3'b001, 1'b0, 8'h01, 8'h02, 8'h03, 3'd1, 10'h004, 1'b1, 1'b0,
           mk(6'b000000, 3'b000, 1'b0, 8'h00, 8'h00, 8'h00, 3'd0, 10'h000, 4'd15));
      step("sat_stall", 6'b000000, 3'b000, 1'b0, 8'h09, 8'h0A, 8'h0B, 3'd4, 10'h10C, 1'b0, 1'b0,
           mk(6'b000000, 3'b000, 1'b0, 8'h09, 8'h0A, 8'h0B, 3'd4, 10'h10C, 4'd15));
      step("valid_after_sat", 6'b010011, 3'b100, 1'b1, 8'hC0, 8'h0C, 8'h3F, 3'd6, 10'h2F0, 1'b0, 1'b0,
           mk(6'b010011, 3'b100, 1'b1, 8'hC0, 8'h0C, 8'h3F, 3'd6, 10'h2F0, 4'd15));

      wait_cnt = 0;
      while (exp_q.size() != 0 && wait_cnt < 10) begin
         @(negedge clk);
         wait_cnt++;
      end
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/id_ex_stage_reg.md
Name: id_ex_stage_reg

Overview:
ID/EX pipeline register directly downstream of the hazard control mux. Captures the (possibly zeroed) decode control bundle, operands, immediate and destination register each cycle, and presents them to the EX stage. Supports downstream hold, branch flush and a valid tag. Provides a saturating bubble counter for performance debug.

Parameters:
DATA_W, 8, operand/immediate width
REG_ADDR_W, 3, register-file address width
PC_W, 10, program counter width
CNT_W, 16, bubble counter width

Ports:
clk  in  1  pipeline clock, rising edge
rst_n  in  1  asynchronous active-low reset
writeEnable_in, memRead_in, memWrite_in, branch_in, ALUSrc_in, MemToReg_in  in  1 each  control bits from hazard control mux
OP_in  in  3  ALU op from hazard control mux
id_valid  in  1  ID holds a real instruction (0 while hazard stall is asserted)
rd1_in, rd2_in  in  DATA_W  register-file read data
imm_in  in  DATA_W  sign/zero-extended immediate
dst_in  in  REG_ADDR_W  destination register index
pc_in  in  PC_W  PC of the ID instruction
hold  in  1  EX/MEM cannot accept; freeze register
flush  in  1  taken branch/redirect; kill contents
writeEnable, memRead, memWrite, branch, ALUSrc, MemToReg  out  1 each  registered control
OP  out  3  registered ALU op
ex_valid  out  1  EX holds a real instruction
rd1, rd2, imm  out  DATA_W  registered data
dst  out  REG_ADDR_W  registered destination
pc  out  PC_W  registered PC
bubble_count  out  CNT_W  bubbles inserted since reset, saturating

Behaviour:
- Reset (rst_n=0, asynchronous, takes effect without a clock edge): all outputs 0, ex_valid=0, bubble_count=0. Released synchronously on next rising edge.
- Per rising edge, priority: flush > hold > load.
- flush=1: all control outputs and OP set to 0, ex_valid=0. Data fields (rd1, rd2, imm, dst, pc) are don't-care; they are cleared to 0. Flush wins even when hold=1.
- hold=1, flush=0: every output keeps its value. bubble_count unchanged.
- Load (hold=0, flush=0): every output takes its _in value. ex_valid takes id_valid.
- When id_valid=0, control outputs are loaded as given. The upstream mux has already zeroed them. This block does not re-gate them.
- Bubble: on a load edge with id_valid=0, or on any flush edge, bubble_count increments by 1.
- bubble_count saturates at 2^CNT_W-1 and does not wrap. It is unaffected by hold-only edges.
- Latency: 1 cycle from input to output. No combinational path from any input to any output.
- Reset asserted mid-hold or mid-flush: the reset values apply immediately and override both.

Test Plan:
- Reset: drive rst_n=0 asynchronously mid-cycle with outputs non-zero -> all outputs 0 before the next clk edge; bubble_count=0.
- Load: id_valid=1, writeEnable_in=1, OP_in=3'b101, rd1_in=8'h3C, dst_in=3'd4, pc_in=10'h012 -> next edge: same values on outputs, ex_valid=1, bubble_count=0.
- Hold: after load, set hold=1 for 3 cycles with different inputs (OP_in=3'b010) -> OP stays 3'b101, ex_valid stays 1, bubble_count stays 0.
- Flush beats hold: hold=1, flush=1, memWrite=1 held -> next edge: memWrite=0, OP=0, ex_valid=0, bubble_count=1.
- Stall bubble: id_valid=0 with all control_in=0 for 2 load edges -> ex_valid=0 both cycles, bubble_count increments by 2.
- Saturation: CNT_W=4, bubble_count at 15, then 3 flush edges -> bubble_count stays 15.
